// File: rtl/main_mem_resp.sv
// main_mem_resp: word-addressed backing RAM with a fixed-latency request/ready handshake
// Optional feature macro: MAIN_MEM_LATENCY_EN (when undefined, LATENCY is ignored and the latency is 1)
module main_mem_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] mem_a,
    input  logic [31:0] mem_st_data,
    input  logic        mem_access,
    input  logic        mem_write,
    output logic [31:0] mem_data,
    output logic        mem_ready,
    output logic        mem_busy
);
`ifdef MAIN_MEM_LATENCY_EN
    localparam int EL = LATENCY;
`else
    localparam int EL = 1;
    localparam int unused_latency = LATENCY;
`endif
    localparam logic [3:0] CNT_INIT = 4'(EL - 1);

    typedef enum logic [1:0] {IDLE, BUSY, READY} state_t;

    state_t state;
    logic [3:0] cnt;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [31:0] wd_q;
    logic wr_q;
    logic [31:0] ram [2**DEPTH_LOG2];

    logic [DEPTH_LOG2-1:0] word;
    logic changed;
    logic done;
    logic unused_addr;

    assign word = mem_a[DEPTH_LOG2+1:2];
    assign changed = {word, mem_write} != {addr_q, wr_q};
    assign done = state == BUSY && mem_access && !changed && cnt == 4'd0;
    assign mem_busy = state != IDLE;
    assign unused_addr = &{1'b0, mem_a[1:0], mem_a[31:DEPTH_LOG2+2]};

    // Request FSM: accept, count down, restart on a changed request, abort when access drops
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            cnt <= 4'd0;
            addr_q <= '0;
            wd_q <= 32'd0;
            wr_q <= 1'b0;
            mem_ready <= 1'b0;
            mem_data <= 32'd0;
        end else begin
            mem_ready <= 1'b0;
            case (state)
                IDLE: if (mem_access) begin
                    addr_q <= word;
                    wd_q <= mem_st_data;
                    wr_q <= mem_write;
                    cnt <= CNT_INIT;
                    state <= BUSY;
                end
                BUSY: if (!mem_access) begin
                    cnt <= 4'd0;
                    state <= IDLE;
                end else if (changed) begin
                    addr_q <= word;
                    wd_q <= mem_st_data;
                    wr_q <= mem_write;
                    cnt <= CNT_INIT;
                end else if (cnt == 4'd0) begin
                    state <= READY;
                    mem_ready <= 1'b1;
                    mem_data <= wr_q ? mem_data : ram[addr_q];
                end else begin
                    cnt <= cnt - 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // RAM write on completion of a write request; contents survive reset
    always_ff @(posedge clk) begin
        if (done && wr_q) ram[addr_q] <= wd_q;
    end
endmodule

// File: tb/tb_main_mem_resp.sv
// tb_main_mem_resp: randomized self-checking bench for main_mem_resp against a word-array model
module tb_main_mem_resp;
    localparam int DL = 10;
    localparam int LAT = 4;
`ifdef MAIN_MEM_LATENCY_EN
    localparam int EL = LAT;
`else
    localparam int EL = 1;
`endif

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic [31:0] mem_a = 32'd0;
    logic [31:0] mem_st_data = 32'd0;
    logic mem_access = 1'b0;
    logic mem_write = 1'b0;
    logic [31:0] mem_data;
    logic mem_ready;
    logic mem_busy;

    int tests = 0;
    int fails = 0;
    logic [31:0] mdl [1024];
    logic [31:0] last_rd = 32'd0;

    main_mem_resp #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
        .clk(clk),
        .clr(clr),
        .mem_a(mem_a),
        .mem_st_data(mem_st_data),
        .mem_access(mem_access),
        .mem_write(mem_write),
        .mem_data(mem_data),
        .mem_ready(mem_ready),
        .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[DL+1:2]);
    endfunction

    function automatic logic [31:0] mk_addr(input int w);
        logic [31:0] r;
        logic [31:0] wv;
        r = $urandom;
        wv = w;
        return {r[31:12], wv[9:0], r[1:0]};
    endfunction

    task automatic edge_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // waits for mem_ready, checking it arrives after exactly exp_n rising edges
    task automatic wait_ready(input string tag, input int exp_n, input bit scr, output bit got);
        int n;
        n = 0;
        got = 1'b0;
        while (n < 40 && !got) begin
            edge_step();
            n++;
            if (mem_ready) got = 1'b1;
            else if (scr) mem_st_data = $urandom;
        end
        chk({tag, "_lat"}, n, exp_n);
        chk({tag, "_busy"}, {31'd0, mem_busy}, 32'd1);
    endtask

    task automatic finish_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                              input logic wr, input bit got);
        if (got && wr) mdl[widx(a)] = d;
        if (got && !wr) last_rd = mdl[widx(a)];
        chk({tag, "_data"}, mem_data, last_rd);
        mem_access = 1'b0;
        edge_step();
        chk({tag, "_pulse"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_idle"}, {31'd0, mem_busy}, 32'd0);
    endtask

    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic wr, input bit scr);
        bit got;
        mem_a = a;
        mem_st_data = d;
        mem_write = wr;
        mem_access = 1'b1;
        wait_ready(tag, EL + 1, scr, got);
        finish_req(tag, a, d, wr, got);
    endtask

    task automatic do_abort(input string tag, input logic [31:0] a, input logic [31:0] d,
                            input logic wr, input int k);
        mem_a = a;
        mem_st_data = d;
        mem_write = wr;
        mem_access = 1'b1;
        repeat (k) begin
            edge_step();
            chk({tag, "_early"}, {31'd0, mem_ready}, 32'd0);
            chk({tag, "_busy"}, {31'd0, mem_busy}, 32'd1);
        end
        mem_access = 1'b0;
        repeat (3) begin
            mem_write = 1'($urandom);
            edge_step();
            chk({tag, "_nordy"}, {31'd0, mem_ready}, 32'd0);
        end
        chk({tag, "_idle"}, {31'd0, mem_busy}, 32'd0);
        chk({tag, "_data"}, mem_data, last_rd);
    endtask

    task automatic do_restart(input string tag, input logic [31:0] a1, input logic wr1,
                              input logic [31:0] a2, input logic [31:0] d2, input logic wr2,
                              input int j);
        bit got;
        mem_a = a1;
        mem_st_data = $urandom;
        mem_write = wr1;
        mem_access = 1'b1;
        repeat (j) begin
            edge_step();
            chk({tag, "_early"}, {31'd0, mem_ready}, 32'd0);
        end
        mem_a = a2;
        mem_st_data = d2;
        mem_write = wr2;
        wait_ready(tag, EL + 1, 1'b0, got);
        finish_req(tag, a2, d2, wr2, got);
    endtask

    task automatic do_reset(input string tag, input logic [31:0] a, input int k);
        mem_a = a;
        mem_st_data = $urandom;
        mem_write = 1'b1;
        mem_access = 1'b1;
        repeat (k) edge_step();
        clr = 1'b1;
        #1;
        chk({tag, "_rdy"}, {31'd0, mem_ready}, 32'd0);
        chk({tag, "_busy"}, {31'd0, mem_busy}, 32'd0);
        chk({tag, "_data"}, mem_data, 32'd0);
        last_rd = 32'd0;
        mem_access = 1'b0;
        @(negedge clk);
        clr = 1'b0;
        do_req({tag, "_rd"}, a, 32'd0, 1'b0, 1'b0);
    endtask

    initial begin
        bit got;
        int w1, w2;
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, mem_ready}, 32'd0);
        chk("rst_busy", {31'd0, mem_busy}, 32'd0);
        chk("rst_data", mem_data, 32'd0);
        clr = 1'b0;
        for (int w = 0; w < 48; w++) do_req("init", mk_addr(w), $urandom, 1'b1, 1'b0);

        do_req("w10", 32'h10, 32'hDEADBEEF, 1'b1, 1'b1);
        do_req("r10", 32'h10, 32'd0, 1'b0, 1'b0);
        chk("r10_val", mem_data, 32'hDEADBEEF);

        do_abort("ab20", 32'h20, 32'h12345678, 1'b1, EL < 3 ? EL : 3);
        do_req("r20", 32'h20, 32'd0, 1'b0, 1'b0);

        do_restart("rs40", 32'h40, 1'b0, 32'h80, 32'd0, 1'b0, EL < 2 ? EL : 2);

        do_reset("clr44", 32'h44, EL < 2 ? EL : 2);

        do_req("w1004", 32'h1004, 32'hA5A5A5A5, 1'b1, 1'b0);
        do_req("r4", 32'h4, 32'd0, 1'b0, 1'b0);
        chk("r4_alias", mem_data, 32'hA5A5A5A5);

        mem_a = 32'h0;
        mem_write = 1'b0;
        mem_access = 1'b1;
        wait_ready("b2b0", EL + 1, 1'b0, got);
        last_rd = mdl[0];
        chk("b2b0_data", mem_data, last_rd);
        mem_a = 32'h4;
        wait_ready("b2b1", EL + 2, 1'b0, got);
        finish_req("b2b1", 32'h4, 32'd0, 1'b0, got);

        for (int i = 0; i < 150; i++) begin
            w1 = $urandom_range(47, 0);
            w2 = (w1 + $urandom_range(47, 1)) % 48;
            case ($urandom_range(4, 0))
                0: do_req("rnd_rd", mk_addr(w1), 32'd0, 1'b0, 1'b1);
                1: do_req("rnd_wr", mk_addr(w1), $urandom, 1'b1, 1'b1);
                2: do_abort("rnd_ab", mk_addr(w1), $urandom, 1'($urandom), $urandom_range(EL, 1));
                3: do_restart("rnd_rs", mk_addr(w1), 1'($urandom), mk_addr(w2), $urandom,
                              1'($urandom), $urandom_range(EL, 1));
                default: do_reset("rnd_clr", mk_addr(w1), $urandom_range(EL, 1));
            endcase
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
